// File: rtl/systolic_array_pkg.sv
// Shared definitions for the systolic matrix multiplier: default sizes,
// accumulator width and lane-slice helpers for the packed operand/result buses.
package systolic_array_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int SIZE_DEFAULT       = 4;

  // Accumulator holds the full signed product and wraps on overflow
  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Low bit index of lane `lane` in a packed bus of `width`-bit lanes
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards A rightwards and B
// downwards by one register each, and accumulates their signed product.
module systolic_pe
  import systolic_array_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [DATA_WIDTH-1:0] a_reg;
  logic signed [DATA_WIDTH-1:0] b_reg;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  // Signed multiply sized to the accumulator; the sum wraps modulo 2^ACC_WIDTH
  always_comb begin
    acc_next = acc_reg + (ACC_WIDTH'(a) * ACC_WIDTH'(b));
  end

  // Operand pass-through and accumulation, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else begin
      a_reg   <= a;
      b_reg   <= b;
      acc_reg <= acc_next;
    end
  end

  assign a_out = a_reg;
  assign b_out = b_reg;
  assign acc   = acc_reg;

endmodule

// File: rtl/systolic_array.sv
// SIZE x SIZE output-stationary systolic multiplier. Input lanes are skewed
// so that A[i][k] and B[k][j] meet in PE(i,j); the bottom accumulator row
// is presented on `result`.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int SIZE       = SIZE_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [DATA_WIDTH*SIZE-1:0]   a_in,
  input  logic signed [DATA_WIDTH*SIZE-1:0]   b_in,
  output logic signed [2*DATA_WIDTH*SIZE-1:0] result
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH);

  // a_h[i][j] is the A operand entering PE(i,j); column SIZE is the discarded edge
  logic signed [DATA_WIDTH-1:0] a_h [SIZE][SIZE+1];
  // b_v[i][j] is the B operand entering PE(i,j); row SIZE is the discarded edge
  logic signed [DATA_WIDTH-1:0] b_v [SIZE+1][SIZE];
  logic signed [ACC_WIDTH-1:0]  acc_grid [SIZE][SIZE];
  // Edge outputs and upper-row accumulators have no consumer
  logic                         unused_pe [SIZE][SIZE];

  genvar gi, gj;

  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
        assign a_h[0][0] = a_in[lane_lsb(0, DATA_WIDTH) +: DATA_WIDTH];
        assign b_v[0][0] = b_in[lane_lsb(0, DATA_WIDTH) +: DATA_WIDTH];
      end else begin : g_delay
        logic signed [DATA_WIDTH-1:0] a_dly_reg [gi];
        logic signed [DATA_WIDTH-1:0] b_dly_reg [gi];

        // Lane gi is delayed gi cycles so operands of one step stay aligned
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int k = 0; k < gi; k++) begin
              a_dly_reg[k] <= '0;
              b_dly_reg[k] <= '0;
            end
          end else begin
            a_dly_reg[0] <= a_in[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
            b_dly_reg[0] <= b_in[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
            for (int k = 1; k < gi; k++) begin
              a_dly_reg[k] <= a_dly_reg[k-1];
              b_dly_reg[k] <= b_dly_reg[k-1];
            end
          end
        end

        assign a_h[gi][0] = a_dly_reg[gi-1];
        assign b_v[0][gi] = b_dly_reg[gi-1];
      end
    end

    for (gi = 0; gi < SIZE; gi++) begin : g_row
      for (gj = 0; gj < SIZE; gj++) begin : g_col
        systolic_pe #(
          .DATA_WIDTH (DATA_WIDTH),
          .ACC_WIDTH  (ACC_WIDTH)
        ) u_pe (
          .clk   (clk),
          .rst   (rst),
          .a     (a_h[gi][gj]),
          .b     (b_v[gi][gj]),
          .a_out (a_h[gi][gj+1]),
          .b_out (b_v[gi+1][gj]),
          .acc   (acc_grid[gi][gj])
        );

        assign unused_pe[gi][gj] = ^{a_h[gi][gj+1], b_v[gi+1][gj], acc_grid[gi][gj]};
      end
    end

    for (gj = 0; gj < SIZE; gj++) begin : g_result
      assign result[lane_lsb(gj, ACC_WIDTH) +: ACC_WIDTH] = acc_grid[SIZE-1][gj];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: a history-based reference model predicts
// the bottom row of C after every edge; predictions are queued when stimulus
// is driven and compared once the edge has happened.
module tb_systolic_array;

  localparam int DW = 8;
  localparam int SZ = 4;
  localparam int AW = 2 * DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW*SZ-1:0]  a_in;
  logic [DW*SZ-1:0]  b_in;
  logic [AW*SZ-1:0]  result;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int step_cnt  = 0;

  // Operand history since the last reset: row SZ-1 of A and all of B
  logic [DW-1:0]     hist_a[$];
  logic [DW*SZ-1:0]  hist_b[$];
  logic [AW*SZ-1:0]  exp_q[$];

  localparam logic [DW*SZ-1:0] CONST_A = {8'd13, 8'd14, 8'd15, 8'd16};
  localparam logic [DW*SZ-1:0] CONST_B = {8'd1, 8'd2, 8'd3, 8'd4};
  localparam logic [AW*SZ-1:0] CONST_R = {16'd52, 16'd130, 16'd234, 16'd364};

  always #5 clk = ~clk;

  systolic_array #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .result (result)
  );

  // Step t (0-based since reset) reaches PE(SZ-1,j) at edge t+1+SZ-1+j
  function automatic logic [AW*SZ-1:0] model();
    logic [AW*SZ-1:0] r;
    logic [DW*SZ-1:0] bw;
    int n;
    int s;
    int av;
    int bv;
    r = '0;
    n = hist_a.size();
    for (int j = 0; j < SZ; j++) begin
      s = 0;
      for (int t = 0; t <= n - SZ - j; t++) begin
        bw = hist_b[t];
        av = int'($signed(hist_a[t]));
        bv = int'($signed(bw[j*DW +: DW]));
        s += av * bv;
      end
      r[j*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [AW*SZ-1:0] got,
                       input logic [AW*SZ-1:0] exp);
    check_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: result=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [DW*SZ-1:0] a,
                      input logic [DW*SZ-1:0] b);
    logic [AW*SZ-1:0] exp;
    rst  = r;
    a_in = a;
    b_in = b;
    if (r) begin
      hist_a.delete();
      hist_b.delete();
    end else begin
      hist_a.push_back(a[(SZ-1)*DW +: DW]);
      hist_b.push_back(b);
    end
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    step_cnt++;
    exp = exp_q.pop_front();
    $display("step %0d rst=%b a=%h b=%h result=%h", step_cnt, r, a, b, result);
    check("cycle", result, exp);
  endtask

  initial begin
    rst  = 1'b0;
    a_in = '0;
    b_in = '0;

    // Arbitrary pre-reset activity; state is undefined so nothing is checked
    for (int i = 0; i < 2; i++) begin
      a_in = $urandom;
      b_in = $urandom;
      @(posedge clk);
      #1;
    end

    // Reset held two edges with non-zero inputs, then zeros keep it at 0
    step(1'b1, 32'hDEADBEEF, 32'h12345678);
    step(1'b1, 32'hCAFEF00D, 32'h87654321);
    check("reset_zero", result, '0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0);
    check("zero_hold", result, '0);

    // Constant stream from edge 1 after reset
    step(1'b1, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, CONST_A, CONST_B);
    check("const_edge10", result, CONST_R);

    // Identity A against B rows {4k+1..4k+4}
    step(1'b1, '0, '0);
    for (int k = 0; k < SZ; k++) begin
      logic [DW*SZ-1:0] a_col;
      logic [DW*SZ-1:0] b_row;
      a_col = '0;
      a_col[k*DW +: DW] = 8'd1;
      for (int j = 0; j < SZ; j++) b_row[j*DW +: DW] = DW'(k*4 + j + 1);
      step(1'b0, a_col, b_row);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0);
    check("identity", result, {16'd16, 16'd15, 16'd14, 16'd13});

    // Signed wrap: (-128)*(-128) twice overflows to 16'h8000
    step(1'b1, '0, '0);
    for (int i = 0; i < 2; i++) step(1'b0, {8'h80, 24'h0}, {24'h0, 8'h80});
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0);
    check("wrap_lane0", result, {48'h0, 16'h8000});

    // Signed product: -2 * 5 on lane 1
    step(1'b1, '0, '0);
    step(1'b0, {8'hFE, 24'h0}, {16'h0, 8'd5, 8'h0});
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0);
    check("neg_lane1", result, {32'h0, 16'hFFF6, 16'h0});

    // Mid-run reset with inputs held, then the constant sequence restarts
    step(1'b1, '0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, CONST_A, CONST_B);
    step(1'b1, CONST_A, CONST_B);
    check("midrun_reset", result, '0);
    for (int i = 0; i < 10; i++) step(1'b0, CONST_A, CONST_B);
    check("restart_edge10", result, CONST_R);

    // Random operands against the model
    step(1'b1, '0, '0);
    for (int i = 0; i < 12; i++) step(1'b0, $urandom, $urandom);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
